// File: rtl/rf_pkg.sv
// Shared types and default sizes for the parametrised register file.
// Holds the clear-sequencer state encoding and a zero-word constant.
package rf_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;

   localparam logic [RF_DATA_W-1:0] RF_ZERO_WORD = '0;

   typedef enum logic [0:0] {
      RF_IDLE  = 1'b0,
      RF_SWEEP = 1'b1
   } rf_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every entry once, one per cycle, after a clear request.
// Reports busy for the whole sweep and a one-cycle done pulse afterwards.
module rf_clear_seq
   import rf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RF_ADDR_W
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  clear_done,
   output logic                  clr_en,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   rf_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  done_q, done_d;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RF_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; the counter wraps to zero on the final entry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         RF_IDLE: begin
            if (clear_req) begin
               state_d = RF_SWEEP;
            end
         end
         RF_SWEEP: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = RF_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = RF_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decoded straight from flops
   always_comb begin
      busy       = (state_q == RF_SWEEP);
      clr_en     = (state_q == RF_SWEEP);
      clr_addr   = cnt_q;
      clear_done = done_q;
   end

endmodule

// File: rtl/rf_param.sv
// Parametrised two-read/one-write register file with optional zero register,
// write-to-read bypass, registered read outputs and a sequenced clear engine.
module rf_param
   import rf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RF_DATA_W,
   parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 1,
   parameter int unsigned REG_OUT    = 0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  read_enabled,
   input  logic [ADDR_WIDTH-1:0] read_addr_s,
   input  logic [ADDR_WIDTH-1:0] read_addr_t,
   input  logic                  write_enabled,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  clear_req,
   output logic [DATA_WIDTH-1:0] outA,
   output logic [DATA_WIDTH-1:0] outB,
   output logic                  busy,
   output logic                  clear_done
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam logic [DATA_WIDTH-1:0] ZERO_WORD = DATA_WIDTH'(RF_ZERO_WORD);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   logic                  clr_en;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  we_eff;
   logic [DATA_WIDTH-1:0] rd_a, rd_b;

   rf_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear_req  (clear_req),
      .busy       (busy),
      .clear_done (clear_done),
      .clr_en     (clr_en),
      .clr_addr   (clr_addr)
   );

   // Writes are suppressed while sweeping and, optionally, to entry 0
   always_comb begin
      we_eff = write_enabled & ~busy;
      if ((ZERO_REG != 0) && (write_addr == '0)) begin
         we_eff = 1'b0;
      end
   end

   // Array next state; sweep and write never coincide since busy blocks writes
   always_comb begin
      mem_d = mem_q;
      if (clr_en) begin
         mem_d[clr_addr] = ZERO_WORD;
      end
      if (we_eff) begin
         mem_d[write_addr] = write_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[ADDR_WIDTH'(i)] <= ZERO_WORD;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Per-port read value before the optional output register
   always_comb begin
      rd_a = mem_q[read_addr_s];
      rd_b = mem_q[read_addr_t];
      if ((BYPASS != 0) && we_eff && (write_addr == read_addr_s)) begin
         rd_a = write_data;
      end
      if ((BYPASS != 0) && we_eff && (write_addr == read_addr_t)) begin
         rd_b = write_data;
      end
      if ((ZERO_REG != 0) && (read_addr_s == '0)) begin
         rd_a = ZERO_WORD;
      end
      if ((ZERO_REG != 0) && (read_addr_t == '0)) begin
         rd_b = ZERO_WORD;
      end
   end

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic [DATA_WIDTH-1:0] out_a_q, out_a_d;
         logic [DATA_WIDTH-1:0] out_b_q, out_b_d;

         // Capture on read strobe, hold otherwise
         always_comb begin
            out_a_d = out_a_q;
            out_b_d = out_b_q;
            if (read_enabled) begin
               out_a_d = rd_a;
               out_b_d = rd_b;
            end
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               out_a_q <= ZERO_WORD;
               out_b_q <= ZERO_WORD;
            end else begin
               out_a_q <= out_a_d;
               out_b_q <= out_b_d;
            end
         end

         assign outA = out_a_q;
         assign outB = out_b_q;
      end else begin : g_comb_out
         assign outA = read_enabled ? rd_a : ZERO_WORD;
         assign outB = read_enabled ? rd_b : ZERO_WORD;
      end
   endgenerate

endmodule

// File: tb/tb_rf_param.sv
// Self-checking bench for rf_param across four parameter sets.
// Expected read data comes from a bench-side array model via an expectation queue.
module tb_rf_param;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        re = 1'b0;
   logic [4:0]  rs = '0, rt = '0, wa = '0;
   logic        we = 1'b0;
   logic [31:0] wd = '0;
   logic        clr = 1'b0;

   logic        s_re = 1'b0, s_we = 1'b0, s_clr = 1'b0;
   logic [2:0]  s_rs = '0, s_rt = '0, s_wa = '0;
   logic [15:0] s_wd = '0;

   logic [31:0] d_a, d_b, n_a, n_b, r_a, r_b;
   logic [15:0] s_a, s_b;
   logic        d_busy, d_done, n_busy, n_done, r_busy, r_done, s_busy, s_done;

   int total = 0;
   int bad   = 0;
   logic [31:0] model [32];
   logic [31:0] exp_q [$];

   always #5 clock = ~clock;

   rf_param u_def (
      .clock(clock), .reset_n(reset_n), .read_enabled(re), .read_addr_s(rs), .read_addr_t(rt),
      .write_enabled(we), .write_addr(wa), .write_data(wd), .clear_req(clr),
      .outA(d_a), .outB(d_b), .busy(d_busy), .clear_done(d_done));

   rf_param #(.BYPASS(0)) u_nb (
      .clock(clock), .reset_n(reset_n), .read_enabled(re), .read_addr_s(rs), .read_addr_t(rt),
      .write_enabled(we), .write_addr(wa), .write_data(wd), .clear_req(clr),
      .outA(n_a), .outB(n_b), .busy(n_busy), .clear_done(n_done));

   rf_param #(.REG_OUT(1)) u_ro (
      .clock(clock), .reset_n(reset_n), .read_enabled(re), .read_addr_s(rs), .read_addr_t(rt),
      .write_enabled(we), .write_addr(wa), .write_data(wd), .clear_req(clr),
      .outA(r_a), .outB(r_b), .busy(r_busy), .clear_done(r_done));

   rf_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0)) u_sm (
      .clock(clock), .reset_n(reset_n), .read_enabled(s_re), .read_addr_s(s_rs), .read_addr_t(s_rt),
      .write_enabled(s_we), .write_addr(s_wa), .write_data(s_wd), .clear_req(s_clr),
      .outA(s_a), .outB(s_b), .busy(s_busy), .clear_done(s_done));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   function automatic logic [31:0] pat1(input int i);
      return 32'hC0DE_0100 + 32'(i);
   endfunction

   function automatic logic [31:0] pat2(input int i);
      return 32'h7700_0000 | 32'(i);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Write on the shared 32-bit bus; the model follows zero-register rules
   task automatic wr(input int a, input logic [31:0] d);
      we = 1'b1; wa = 5'(a); wd = d;
      tick();
      we = 1'b0;
      model[a] = (a == 0) ? 32'h0 : d;
   endtask

   // Read both ports of the default instance against the model via the queue
   task automatic rd_both(input string tag, input int a, input int b);
      re = 1'b1; rs = 5'(a); rt = 5'(b);
      exp_q.push_back(model[a]);
      exp_q.push_back(model[b]);
      @(negedge clock);
      check_eq(tag, d_a, pop_exp());
      check_eq(tag, d_b, pop_exp());
      tick();
   endtask

   initial begin
      int busy_cnt, done_cnt, done_at;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_busy", {29'h0, d_busy, n_busy, r_busy}, 32'h0);
      check_eq("rst_done", {28'h0, d_done, n_done, r_done, s_done}, 32'h0);
      check_eq("rst_ro_a", r_a, 32'h0);
      reset_n = 1'b1;
      tick();

      // Zero register ignores writes
      wr(0, 32'hDEAD_BEEF);
      wr(2, 32'h1111_1111);
      rd_both("zero_reg", 0, 2);

      // Same-cycle write/read bypass versus old value
      we = 1'b1; wa = 5'd5; wd = 32'hA5A5_A5A5; rs = 5'd5;
      @(negedge clock);
      check_eq("byp_on", d_a, 32'hA5A5_A5A5);
      check_eq("byp_off_pre", n_a, 32'h0);
      tick();
      we = 1'b0; model[5] = 32'hA5A5_A5A5;
      @(negedge clock);
      check_eq("byp_off_post", n_a, 32'hA5A5_A5A5);
      check_eq("ro_byp_cap", r_a, 32'hA5A5_A5A5);
      tick();

      // Registered outputs: one-edge latency, hold when not enabled
      wr(3, 32'h2222_2222);
      rt = 5'd3;
      @(negedge clock);
      check_eq("ro_old", r_b, 32'h1111_1111);
      check_eq("comb_new", d_b, 32'h2222_2222);
      tick();
      check_eq("ro_new", r_b, 32'h2222_2222);
      re = 1'b0; rt = 5'd4;
      @(negedge clock);
      check_eq("comb_re0", d_b, 32'h0);
      tick();
      check_eq("ro_hold", r_b, 32'h2222_2222);

      // Fill, read back, then sweep
      for (int i = 0; i < 32; i++) wr(i, pat1(i));
      for (int i = 0; i < 32; i++) rd_both("fill", i, 31 - i);
      re = 1'b1; rs = 5'd7; rt = 5'd2;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      for (int c = 0; c < 40; c++) begin
         if (c == 10) begin
            we = 1'b1; wa = 5'd7; wd = 32'hFFFF_FFFF;
         end else begin
            we = 1'b0;
         end
         @(negedge clock);
         if (d_busy) busy_cnt++;
         if (d_done) begin
            done_cnt++;
            done_at = c;
         end
         if (c == 4) begin
            check_eq("sweep_live", d_a, pat1(7));
            check_eq("sweep_swept", d_b, 32'h0);
         end
         if (c == 10) check_eq("sweep_nobyp", d_a, 32'h0);
         tick();
      end
      check_eq("busy_len", 32'(busy_cnt), 32'd32);
      check_eq("done_cnt", 32'(done_cnt), 32'd1);
      check_eq("done_at", 32'(done_at), 32'd32);
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      for (int i = 0; i < 32; i++) rd_both("cleared", i, i);
      @(negedge clock);
      check_eq("nb_cleared7", n_a, 32'h0);
      tick();

      // Reset in the middle of a sweep
      for (int i = 1; i < 32; i++) wr(i, pat2(i));
      re = 1'b1; rs = 5'd12;
      tick();
      check_eq("ro_pre_rst", r_a, pat2(12));
      re = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      check_eq("mid_busy", {31'h0, d_busy}, 32'h1);
      reset_n = 1'b0;
      #1;
      re = 1'b1; rs = 5'd20; rt = 5'd31;
      #1;
      check_eq("abort_busy", {31'h0, d_busy}, 32'h0);
      check_eq("abort_done", {31'h0, d_done}, 32'h0);
      check_eq("abort_ro", r_a, 32'h0);
      check_eq("abort_rd", d_b, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      for (int i = 10; i < 32; i++) rd_both("post_abort", i, i);
      busy_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (d_busy) busy_cnt++;
         tick();
      end
      check_eq("abort_idle", 32'(busy_cnt), 32'd0);

      // Small instance: no zero register, 8-entry sweep
      s_we = 1'b1; s_wa = 3'd0; s_wd = 16'h1234;
      tick();
      s_wa = 3'd7; s_wd = 16'hBEEF;
      tick();
      s_we = 1'b0;
      s_re = 1'b1; s_rs = 3'd0; s_rt = 3'd7;
      exp_q.push_back(32'h1234);
      exp_q.push_back(32'hBEEF);
      @(negedge clock);
      check_eq("sm_e0", {16'h0, s_a}, pop_exp());
      check_eq("sm_e7", {16'h0, s_b}, pop_exp());
      tick();
      s_clr = 1'b1;
      tick();
      s_clr = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (s_busy) busy_cnt++;
         if (s_done) done_cnt++;
         tick();
      end
      check_eq("sm_busy_len", 32'(busy_cnt), 32'd8);
      check_eq("sm_done_cnt", 32'(done_cnt), 32'd1);
      @(negedge clock);
      check_eq("sm_clr_a", {16'h0, s_a}, 32'h0);
      check_eq("sm_clr_b", {16'h0, s_b}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/rf_param.md
Name: rf_param

Overview:
- Parametrised successor to the fixed 32x32 two-read/one-write MIPS register file.
- Data width and depth are generic. Options cover a hardwired zero register, write-to-read bypass and registered read outputs.
- Adds a sequenced clear engine that zeroes the array one entry per cycle.
- Sits in the decode stage, feeding the ALU operand muxes (outA = rs, outB = rt).

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port
REG_OUT, 0, 0 = combinational read; 1 = read outputs registered (1-cycle latency)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
read_enabled  in  1  read strobe for both ports
read_addr_s  in  ADDR_WIDTH  port A (rs) address
read_addr_t  in  ADDR_WIDTH  port B (rt) address
write_enabled  in  1  write strobe
write_addr  in  ADDR_WIDTH  write address
write_data  in  DATA_WIDTH  write data
clear_req  in  1  start a clear sweep (sampled in IDLE only)
outA  out  DATA_WIDTH  port A read data
outB  out  DATA_WIDTH  port B read data
busy  out  1  clear sweep in progress
clear_done  out  1  one-cycle pulse at end of sweep

Behaviour:
- Reset (reset_n=0, asynchronous):
  - all DEPTH entries go to 0; outA=outB=0, busy=0, clear_done=0; FSM goes to IDLE, sweep counter to 0.
  - Reset asserted mid-sweep aborts the sweep. Array is all-zero after release.
- Write:
  - Effective write = write_enabled & ~busy & ~(ZERO_REG & write_addr==0).
  - Array is updated on the rising edge.
  - Writes during busy are dropped silently.
- Read value for each port, computed before REG_OUT:
  - ZERO_REG and addr==0 -> 0.
  - Else, if BYPASS and an effective write has write_addr==addr -> write_data.
  - Else -> array[addr].
- REG_OUT=0:
  - outX = read_enabled ? read value : 0 (combinational).
  - BYPASS=0: a read of the address being written returns the old contents until the edge.
- REG_OUT=1:
  - On a rising edge with read_enabled=1, outX captures the read value.
  - With read_enabled=0, outX holds.
  - With BYPASS=1, the captured value equals the data being written on that same edge.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP when clear_req=1 at a rising edge. That edge still performs any effective write.
  - SWEEP: at each edge, entry[cnt] <= 0 and cnt increments. busy=1 throughout.
  - At the edge where cnt==DEPTH-1: clear the last entry, cnt wraps to 0, go to IDLE. clear_done=1 for the following cycle only.
  - Total: busy is high for exactly DEPTH cycles.
  - clear_req during SWEEP is ignored; no queuing.
  - Reads stay live during SWEEP and return current array contents. Already-swept entries read 0; bypass is inactive because no write is effective.
- Simultaneous events:
  - Both read ports may address the same entry.
  - Read and write to the same entry in the same cycle follows the BYPASS rule above.

Decomposition:
- Package rf_pkg holds:
  - clear FSM state enum (RF_IDLE, RF_SWEEP);
  - default width constants RF_DATA_W=32, RF_ADDR_W=5;
  - a zero-word constant.
- One sub-module, rf_clear_seq: clear FSM plus sweep counter.
  - Inputs: clock, reset_n, clear_req.
  - Outputs: busy, clear_done, clr_en, clr_addr.
- Array storage and read muxing stay in rf_param.

Test Plan:
1. Defaults: reset, then write 0xDEADBEEF to entry 0 and 0x11111111 to entry 2; read s=0, t=2 -> outA=0, outB=0x11111111.
2. BYPASS=1, REG_OUT=0: write entry 5=0xA5A5A5A5 while read_addr_s=5 in the same cycle -> outA=0xA5A5A5A5 before the edge. Repeat with BYPASS=0 -> old value (0) before the edge, new value after.
3. REG_OUT=1: set read_addr_t=3 (holds 0x22222222) with read_enabled=1 -> outB updates one edge later. Drop read_enabled and change the address -> outB holds 0x22222222.
4. Fill all 32 entries with nonzero data, pulse clear_req -> busy high for exactly 32 cycles. A write of 0xFFFFFFFF to entry 7 during the sweep is dropped. clear_done pulses once. All entries then read 0.
5. Start a sweep, assert reset_n=0 at cycle 10 of the sweep -> outputs 0 immediately, busy=0. After release, entries 10..31 read 0 and the FSM is IDLE.
6. ADDR_WIDTH=3, DATA_WIDTH=16, ZERO_REG=0: write entry 0=0x1234 and entry 7=0xBEEF -> both read back. A clear sweep lasts 8 cycles.
